cpu_core_param: RTL

Parametrised successor to the fixed 19-bit execution core: an accumulator-style processor with configurable data width and hardware return-stack depth. It adds three things the 19-bit core lacks:
- a valid/ready instruction-fetch handshake;
- a req/ack memory handshake with wait states;
- zero/carry flags, variable shift amounts, and fault detection (stack overflow/underflow, illegal opcode).

It sits between the instruction source, the register operand path (r2/r3) and the data-memory port.

---
 rtl/cpu_core_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parametrised accumulator core with fetch/memory handshakes
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   instr_valid/instr       instruction source; instr_ready high while in FETCH
//   r2, r3                  operands, sampled on the EXEC edge
//   r1, pc, sp, zf, cf      accumulator, program counter, stack occupancy, flags
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   data-memory request/ack port
//   halted, fault, fault_code   terminal status (01 overflow, 10 underflow, 11 illegal)
module cpu_core_param #(
    parameter  int DATA_W      = 19,
    parameter  int STACK_DEPTH = 256,
    localparam int ADDR_W      = DATA_W - 5,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r1,
    output logic [ADDR_W-1:0] pc,
    output logic [SP_W-1:0]   sp,
    output logic              zf,
    output logic              cf,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                           OP_DIV = 5'b00011, OP_INC = 5'b00100, OP_DEC = 5'b00101,
                           OP_AND = 5'b00110, OP_OR  = 5'b00111, OP_XOR = 5'b01000,
                           OP_NOT = 5'b01001, OP_NAND = 5'b01010, OP_NOR = 5'b01011,
                           OP_JMP = 5'b01100, OP_BEQ = 5'b01101, OP_BNE = 5'b01110,
                           OP_CALL = 5'b01111, OP_RET = 5'b10000, OP_LD = 5'b10001,
                           OP_ST  = 5'b10010, OP_SHL = 5'b10110, OP_SHR = 5'b10111,
                           OP_HALT = 5'b11111;

    localparam logic [DATA_W:0]   ONE_X   = {{DATA_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]   ONE_S   = {{(SP_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]   DEPTH_S = STACK_DEPTH[SP_W-1:0];
    localparam logic [DATA_W-1:0] DW_V    = DATA_W[DATA_W-1:0];

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_HALT, S_FAULT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] ir_q, r1_q, wdata_q;
    logic [ADDR_W-1:0] pc_q, maddr_q;
    logic [SP_W-1:0]   sp_q;
    logic              zf_q, cf_q, req_q, we_q, halt_q, fault_q;
    logic [1:0]        code_q;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [4:0]        opc;
    logic [ADDR_W-1:0] addr, pc_inc;
    logic [SP_W-1:0]   sp_m1;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cf;

    assign opc    = ir_q[DATA_W-1 -: 5];
    assign addr   = ir_q[ADDR_W-1:0];
    assign pc_inc = pc_q + ONE_A;
    assign sp_m1  = sp_q - ONE_S;

    // Carry/borrow comes from the extra top bit of a (DATA_W+1)-bit add or
    // subtract; ops that do not touch cf pass the current flag through.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_cf  = cf_q;
        case (opc)
            OP_ADD:  begin wide = {1'b0, r2} + {1'b0, r3}; alu_res = wide[DATA_W-1:0]; alu_cf = wide[DATA_W]; end
            OP_SUB:  begin wide = {1'b0, r2} - {1'b0, r3}; alu_res = wide[DATA_W-1:0]; alu_cf = wide[DATA_W]; end
            OP_INC:  begin wide = {1'b0, r1_q} + ONE_X;    alu_res = wide[DATA_W-1:0]; alu_cf = wide[DATA_W]; end
            OP_DEC:  begin wide = {1'b0, r1_q} - ONE_X;    alu_res = wide[DATA_W-1:0]; alu_cf = wide[DATA_W]; end
            OP_MUL:  alu_res = r2 * r3;
            OP_DIV:  alu_res = (r3 == '0) ? '1 : r2 / r3;
            OP_AND:  alu_res = r2 & r3;
            OP_OR:   alu_res = r2 | r3;
            OP_XOR:  alu_res = r2 ^ r3;
            OP_NOT:  alu_res = ~r2;
            OP_NAND: alu_res = ~(r2 & r3);
            OP_NOR:  alu_res = ~(r2 | r3);
            OP_SHL:  alu_res = (r3 >= DW_V) ? '0 : (r2 << r3);
            OP_SHR:  alu_res = (r3 >= DW_V) ? '0 : (r2 >> r3);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            r1_q    <= '0;
            pc_q    <= '0;
            sp_q    <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            case (state_q)
                S_FETCH: if (instr_valid) begin
                    ir_q    <= instr;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    case (opc)
                        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC, OP_AND, OP_OR,
                        OP_XOR, OP_NOT, OP_NAND, OP_NOR, OP_SHL, OP_SHR: begin
                            r1_q <= alu_res;
                            zf_q <= (alu_res == '0);
                            cf_q <= alu_cf;
                            pc_q <= pc_inc;
                        end
                        OP_JMP: pc_q <= addr;
                        OP_BEQ: pc_q <= (r1_q == r2) ? addr : pc_inc;
                        OP_BNE: pc_q <= (r1_q != r2) ? addr : pc_inc;
                        OP_CALL: if (sp_q == DEPTH_S) begin
                            fault_q <= 1'b1;
                            code_q  <= 2'b01;
                            state_q <= S_FAULT;
                        end else begin
                            sp_q <= sp_q + ONE_S;
                            pc_q <= addr;
                        end
                        OP_RET: if (sp_q == '0) begin
                            fault_q <= 1'b1;
                            code_q  <= 2'b10;
                            state_q <= S_FAULT;
                        end else begin
                            sp_q <= sp_m1;
                            pc_q <= stack_q[sp_m1[IDX_W-1:0]];
                        end
                        OP_LD, OP_ST: begin
                            req_q   <= 1'b1;
                            maddr_q <= addr;
                            if (opc == OP_ST) begin
                                we_q    <= 1'b1;
                                wdata_q <= r1_q;
                            end
                            state_q <= S_MEM;
                        end
                        OP_HALT: begin
                            halt_q  <= 1'b1;
                            state_q <= S_HALT;
                        end
                        default: begin
                            fault_q <= 1'b1;
                            code_q  <= 2'b11;
                            state_q <= S_FAULT;
                        end
                    endcase
                end
                S_MEM: if (mem_ack) begin
                    if (!we_q) begin
                        r1_q <= mem_rdata;
                        zf_q <= (mem_rdata == '0);
                    end
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    pc_q    <= pc_inc;
                    state_q <= S_FETCH;
                end
                default: state_q <= state_q;
            endcase
        end
    end

    // Return-stack storage carries no reset; sp_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_EXEC && opc == OP_CALL && sp_q != DEPTH_S)
            stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
    end

    assign instr_ready = (state_q == S_FETCH);
    assign r1          = r1_q;
    assign pc          = pc_q;
    assign sp          = sp_q;
    assign zf          = zf_q;
    assign cf          = cf_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = wdata_q;
    assign halted      = halt_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
endmodule
